lfsr_crypt_engine: RTL and testbench

Hardware LFSR stream-cipher engine. It replaces the software encryption program with a fixed-function datapath. It reads a raw message from data memory, frames it with ASCII-space pre/post padding, XORs each byte with a programmable-tap LFSR sequence, inserts an even-parity MSB, and writes the frame back to memory. A decrypt mode reverses the operation and counts parity errors. It sits beside the core as a second master on the data-memory port and uses the same Start/Ack handshake as TopLevel.

---
 rtl/lfsr_crypt_engine.sv | 169 ++++++++++++++++
 tb/tb_lfsr_crypt_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_crypt_engine.sv
// LFSR stream-cipher engine: frames a message with space padding, XORs it
// with a programmable LFSR stream and adds even parity; decrypt reverses it.
module lfsr_crypt_engine #(
    parameter int LFSR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int FRAME_LEN = 64,
    parameter int MSG_MAX   = 54,
    parameter int PRE_MIN   = 10,
    parameter int PRE_MAX   = 26
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Ack,
    output logic              Busy,
    input  logic              Mode,
    input  logic [7:0]        PreLen,
    input  logic [LFSR_W-1:0] Taps,
    input  logic [LFSR_W-1:0] LfsrInit,
    input  logic [ADDR_W-1:0] SrcBase,
    input  logic [ADDR_W-1:0] DstBase,
    output logic              MemRdEn,
    output logic [ADDR_W-1:0] MemRdAddr,
    input  logic [DATA_W-1:0] MemRdData,
    output logic              MemWrEn,
    output logic [ADDR_W-1:0] MemWrAddr,
    output logic [DATA_W-1:0] MemWrData,
    output logic [7:0]        ErrCount
);

    localparam int IDX_W = $clog2(FRAME_LEN + PRE_MAX + MSG_MAX + 1);
    localparam logic [DATA_W-1:0] SPACE = DATA_W'(8'h20);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD,
        WR,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic              armed;
    logic              mode_q;
    logic [LFSR_W-1:0] taps_q;
    logic [LFSR_W-1:0] lfsr;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [IDX_W-1:0]  pre_q;
    logic [IDX_W-1:0]  idx;

    logic [7:0]        pre_c;
    logic              in_win;
    logic              last;
    logic [IDX_W-1:0]  off;
    logic [DATA_W-1:0] rd_byte;
    logic [DATA_W-1:0] enc_raw;
    logic [DATA_W-1:0] enc;
    logic [DATA_W-1:0] dec;
    logic              par_err;
    logic              fb;

    assign pre_c = (PreLen < 8'(PRE_MIN)) ? 8'(PRE_MIN) :
                   (PreLen > 8'(PRE_MAX)) ? 8'(PRE_MAX) : PreLen;

    assign in_win  = (idx >= pre_q) && (idx < pre_q + IDX_W'(MSG_MAX));
    assign last    = (idx == IDX_W'(FRAME_LEN - 1));
    assign off     = mode_q ? idx : idx - pre_q;
    assign rd_byte = (mode_q || in_win) ? MemRdData : SPACE;
    assign enc_raw = rd_byte ^ {1'b0, lfsr};
    assign enc     = {^enc_raw[DATA_W-2:0], enc_raw[DATA_W-2:0]};
    assign dec     = {1'b0, MemRdData[DATA_W-2:0] ^ lfsr};
    assign par_err = MemRdData[DATA_W-1] != ^MemRdData[DATA_W-2:0];
    assign fb      = ^(lfsr & taps_q);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (armed && !Start) state_nx = LOAD;
            LOAD: state_nx = RD;
            RD:   state_nx = WR;
            WR:   state_nx = last ? DONE : RD;
            DONE: if (Start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Busy      = 1'b0;
        Ack       = 1'b0;
        MemRdEn   = 1'b0;
        MemRdAddr = '0;
        MemWrEn   = 1'b0;
        MemWrAddr = '0;
        MemWrData = '0;
        unique case (state)
            LOAD: Busy = 1'b1;
            RD: begin
                Busy = 1'b1;
                if (mode_q || in_win) begin
                    MemRdEn   = 1'b1;
                    MemRdAddr = src_q + ADDR_W'(off);
                end
            end
            WR: begin
                Busy      = 1'b1;
                // a reset landing on a write cycle must not commit that byte
                MemWrEn   = Reset;
                MemWrAddr = dst_q + ADDR_W'(idx);
                MemWrData = mode_q ? dec : enc;
            end
            DONE: Ack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            armed    <= 1'b0;
            mode_q   <= 1'b0;
            taps_q   <= '0;
            lfsr     <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            pre_q    <= '0;
            idx      <= '0;
            ErrCount <= '0;
        end else begin
            // a run needs Start seen high first, so a held-low Start cannot re-trigger
            if (state == IDLE && armed && !Start) begin
                armed <= 1'b0;
            end else if (Start) begin
                armed <= 1'b1;
            end
            unique case (state)
                LOAD: begin
                    mode_q   <= Mode;
                    taps_q   <= Taps;
                    src_q    <= SrcBase;
                    dst_q    <= DstBase;
                    pre_q    <= IDX_W'(pre_c);
                    lfsr     <= (LfsrInit == '0) ? LFSR_W'(1) : LfsrInit;
                    idx      <= '0;
                    ErrCount <= '0;
                end
                WR: begin
                    lfsr <= {lfsr[LFSR_W-2:0], fb};
                    idx  <= idx + 1'b1;
                    if (mode_q && par_err && ErrCount != 8'hFF) begin
                        ErrCount <= ErrCount + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// Directed bench for lfsr_crypt_engine with a 256-byte 1-cycle-latency memory
// and a byte-level reference model of the cipher frame.
module tb_lfsr_crypt_engine;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic       Busy;
    logic       Mode;
    logic [7:0] PreLen;
    logic [6:0] Taps;
    logic [6:0] LfsrInit;
    logic [7:0] SrcBase;
    logic [7:0] DstBase;
    logic       MemRdEn;
    logic [7:0] MemRdAddr;
    logic [7:0] MemRdData;
    logic       MemWrEn;
    logic [7:0] MemWrAddr;
    logic [7:0] MemWrData;
    logic [7:0] ErrCount;

    logic [7:0] mem [256];
    logic       tb_we;
    logic [7:0] tb_waddr;
    logic [7:0] tb_wdata;

    logic [7:0] msg   [54];
    logic [7:0] exp_c [64];
    logic [7:0] exp_p [64];

    int checks = 0;
    int passes = 0;
    int cyc;
    int first_rd;
    int bad;
    logic [7:0] first_addr;

    lfsr_crypt_engine dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Busy(Busy),
        .Mode(Mode), .PreLen(PreLen), .Taps(Taps), .LfsrInit(LfsrInit),
        .SrcBase(SrcBase), .DstBase(DstBase),
        .MemRdEn(MemRdEn), .MemRdAddr(MemRdAddr), .MemRdData(MemRdData),
        .MemWrEn(MemWrEn), .MemWrAddr(MemWrAddr), .MemWrData(MemWrData),
        .ErrCount(ErrCount)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (MemRdEn) MemRdData <= mem[MemRdAddr];
        if (MemWrEn) mem[MemWrAddr] <= MemWrData;
        if (tb_we) mem[tb_waddr] <= tb_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge Clk);
        tb_we = 1'b0;
    endtask

    task automatic model(input logic [7:0] pre_in, input logic [6:0] tp, input logic [6:0] init);
        int pre;
        logic [6:0] l;
        logic [7:0] b;
        logic [7:0] c;
        pre = (pre_in < 8'd10) ? 10 : (pre_in > 8'd26) ? 26 : int'(pre_in);
        l = (init == 7'd0) ? 7'd1 : init;
        for (int i = 0; i < 64; i++) begin
            if (i >= pre && i < pre + 54) b = msg[i - pre];
            else b = 8'h20;
            c = b ^ {1'b0, l};
            c[7] = ^c[6:0];
            exp_c[i] = c;
            exp_p[i] = {1'b0, b[6:0]};
            l = {l[5:0], ^(l & tp)};
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] base, input logic plain);
        logic [7:0] a;
        for (int i = 0; i < 64; i++) begin
            a = base + 8'(i);
            check($sformatf("%s[%0d]", tag, i), {24'd0, mem[a]},
                  {24'd0, plain ? exp_p[i] : exp_c[i]});
        end
    endtask

    task automatic run(input logic md, input logic [7:0] pre, input logic [6:0] tp,
                       input logic [6:0] init, input logic [7:0] src, input logic [7:0] dst,
                       input int abort_at);
        @(negedge Clk);
        Mode = md; PreLen = pre; Taps = tp; LfsrInit = init;
        SrcBase = src; DstBase = dst; Start = 1'b1;
        @(negedge Clk);
        check("ack_low_after_start", {31'd0, Ack}, 32'd0);
        Start = 1'b0;
        cyc = 0; first_rd = -1; first_addr = 8'h00;
        while (!Ack && cyc < 400) begin
            @(negedge Clk);
            cyc++;
            if (MemRdEn && first_rd < 0) begin
                first_rd = cyc;
                first_addr = MemRdAddr;
            end
            if (abort_at >= 0 && MemWrEn && MemWrAddr == dst + 8'(abort_at)) begin
                Reset = 1'b0;
                #1;
                check("wr_in_reset_cycle", {31'd0, MemWrEn}, 32'd0);
                @(negedge Clk);
                check("abort_ack", {31'd0, Ack}, 32'd0);
                check("abort_busy", {31'd0, Busy}, 32'd0);
                check("abort_wren", {31'd0, MemWrEn}, 32'd0);
                Reset = 1'b1;
                return;
            end
        end
        check("ack_reached", {31'd0, Ack}, 32'd1);
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Mode = 1'b0; PreLen = 8'd0;
        Taps = 7'd0; LfsrInit = 7'd0; SrcBase = 8'd0; DstBase = 8'd0;
        tb_we = 1'b0; tb_waddr = 8'd0; tb_wdata = 8'd0;
        for (int k = 0; k < 54; k++) msg[k] = 8'h30 + 8'((k * 7) % 75);

        repeat (2) @(negedge Clk);
        check("rst_ack", {31'd0, Ack}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_rden", {31'd0, MemRdEn}, 32'd0);
        check("rst_wren", {31'd0, MemWrEn}, 32'd0);
        check("rst_wraddr", {24'd0, MemWrAddr}, 32'd0);
        check("rst_wrdata", {24'd0, MemWrData}, 32'd0);
        check("rst_errcount", {24'd0, ErrCount}, 32'd0);
        Reset = 1'b1;

        // Start held low since reset must not launch a run
        repeat (3) @(negedge Clk);
        check("no_run_unarmed", {31'd0, Busy}, 32'd0);

        for (int k = 0; k < 54; k++) poke(8'h40 + 8'(k), msg[k]);

        // encrypt: PreLen 29 clamps to 26
        model(8'd29, 7'h7B, 7'h1F);
        run(1'b0, 8'd29, 7'h7B, 7'h1F, 8'h40, 8'h80, -1);
        check("enc_ack_cycles", cyc, 32'd130);
        check("enc_dst0", {24'd0, mem[8'h80]}, 32'h3F);
        check("enc_dst1", {24'd0, mem[8'h81]}, 32'h1E);
        check("enc_errcount", {24'd0, ErrCount}, 32'd0);
        check_frame("enc", 8'h80, 1'b0);

        // decrypt the frame back
        run(1'b1, 8'd29, 7'h7B, 7'h1F, 8'h80, 8'hC0, -1);
        check("dec_ack_cycles", cyc, 32'd130);
        check("dec_errcount", {24'd0, ErrCount}, 32'd0);
        check("dec_first_rd_addr", {24'd0, first_addr}, 32'h80);
        check_frame("dec", 8'hC0, 1'b1);

        // two corrupted parity bits
        poke(8'h83, mem[8'h83] ^ 8'h80);
        poke(8'hA8, mem[8'hA8] ^ 8'h80);
        run(1'b1, 8'd29, 7'h7B, 7'h1F, 8'h80, 8'hC0, -1);
        check("perr_errcount", {24'd0, ErrCount}, 32'd2);
        check_frame("perr", 8'hC0, 1'b1);

        // zero seed and short preamble
        model(8'd5, 7'h60, 7'h00);
        run(1'b0, 8'd5, 7'h60, 7'h00, 8'h40, 8'h80, -1);
        check("seed0_dst0", {24'd0, mem[8'h80]}, 32'h21);
        check("seed0_first_rd_cycle", first_rd, 32'd22);
        check("seed0_first_rd_addr", {24'd0, first_addr}, 32'h40);
        check_frame("seed0", 8'h80, 1'b0);

        bad = 0;
        repeat (50) begin
            @(negedge Clk);
            if (!Ack || Busy || MemWrEn) bad++;
        end
        check("done_hold_bad_cycles", bad, 32'd0);
        check("done_hold_ack", {31'd0, Ack}, 32'd1);

        // reset in the write cycle of byte 20
        model(8'd29, 7'h7B, 7'h1F);
        poke(8'h94, 8'h55);
        run(1'b0, 8'd29, 7'h7B, 7'h1F, 8'h40, 8'h80, 20);
        check("abort_byte19", {24'd0, mem[8'h93]}, {24'd0, exp_c[19]});
        check("abort_byte20_kept", {24'd0, mem[8'h94]}, 32'h55);

        run(1'b0, 8'd29, 7'h7B, 7'h1F, 8'h40, 8'h80, -1);
        check("rerun_ack_cycles", cyc, 32'd130);
        check_frame("rerun", 8'h80, 1'b0);

        // destination wraps past 0xFF
        run(1'b0, 8'd29, 7'h7B, 7'h1F, 8'h40, 8'hE0, -1);
        check("wrap_ack_cycles", cyc, 32'd130);
        check_frame("wrap", 8'hE0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
